// File: rtl/day_2_repeat_scan.sv
// Streaming repeated-digit ID scanner: sums and counts IDs in inclusive ranges whose
// decimal form is two copies (mode 0) or two-or-more copies (mode 1) of a digit block.
module day_2_repeat_scan #(
  parameter int W          = 64,
  parameter int MAX_DIGITS = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         mode,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_lo,
  input  logic [W-1:0] in_hi,
  input  logic         in_last,
  output logic         busy,
  output logic         finished,
  output logic [W-1:0] result,
  output logic [W-1:0] match_count
);

  localparam int DW = 4 * MAX_DIGITS;
  localparam int NW = $clog2(MAX_DIGITS + 1);
  localparam int BW = (W > 1) ? $clog2(W) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ACCEPT  = 3'd1;
  localparam logic [2:0] S_CONVERT = 3'd2;
  localparam logic [2:0] S_SCAN    = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]    state_r;
  logic [2:0]    state_n_s;
  logic          mode_r;
  logic          last_r;
  logic [W-1:0]  hi_r;
  logic [W-1:0]  cand_r;
  logic [W-1:0]  shift_r;
  logic [W-1:0]  acc_r;
  logic [W-1:0]  cnt_r;
  logic [DW-1:0] digits_r;
  logic [NW-1:0] ndig_r;
  logic [BW-1:0] bitcnt_r;

  logic          match_s;
  logic [W-1:0]  acc_next_s;
  logic [W-1:0]  cnt_next_s;
  logic [DW-1:0] dd_adj_s;
  logic [DW-1:0] dd_next_s;
  logic [DW-1:0] bcd_inc_s;

  // Significant digit count; an all-zero image still counts as one digit.
  function automatic logic [NW-1:0] digit_count(input logic [DW-1:0] d);
    logic [NW-1:0] n;
    n = NW'(1);
    for (int i = 1; i < MAX_DIGITS; i++) begin
      n = (d[4*i +: 4] != 4'd0) ? NW'(i + 1) : n;
    end
    return n;
  endfunction

  function automatic logic period_ok(input logic [DW-1:0] d, input int n, input int p);
    logic ok;
    ok = 1'b1;
    for (int j = p; j < n; j++) begin
      ok = ok & (d[4*j +: 4] == d[4*(j-p) +: 4]);
    end
    return ok;
  endfunction

  // n and every p are elaboration constants at each call site, so the modulo folds away.
  function automatic logic rule_ok(input logic [DW-1:0] d, input int n, input logic m);
    logic ok;
    ok = 1'b0;
    if (m == 1'b0) begin
      ok = ((n % 2) == 0) && period_ok(d, n, n / 2);
    end else begin
      for (int p = 1; p < n; p++) begin
        ok = ok | (((n % p) == 0) && period_ok(d, n, p));
      end
    end
    return ok;
  endfunction

  // Repetition rule for the current candidate, selected by its digit count.
  always_comb begin
    match_s = 1'b0;
    for (int n = 2; n <= MAX_DIGITS; n++) begin
      match_s = match_s | ((ndig_r == NW'(n)) && rule_ok(digits_r, n, mode_r));
    end
    acc_next_s = acc_r + (match_s ? cand_r : {W{1'b0}});
    cnt_next_s = cnt_r + {{(W-1){1'b0}}, match_s};
  end

  // Double-dabble step and BCD +1 with ripple carry.
  always_comb begin
    logic carry_v;
    logic [3:0] d_v;
    carry_v   = 1'b1;
    dd_adj_s  = '0;
    bcd_inc_s = '0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      d_v                 = digits_r[4*i +: 4];
      dd_adj_s[4*i +: 4]  = (d_v >= 4'd5) ? d_v + 4'd3 : d_v;
      bcd_inc_s[4*i +: 4] = carry_v ? ((d_v == 4'd9) ? 4'd0 : d_v + 4'd1) : d_v;
      carry_v             = carry_v & (d_v == 4'd9);
    end
    dd_next_s = DW'({dd_adj_s, shift_r[W-1]});
  end

  // Next-state decode.
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      S_IDLE, S_DONE: state_n_s = start ? S_ACCEPT : state_r;
      S_ACCEPT: begin
        if (in_valid) begin
          state_n_s = (in_lo > in_hi) ? (in_last ? S_DONE : S_ACCEPT) : S_CONVERT;
        end else begin
          state_n_s = S_ACCEPT;
        end
      end
      S_CONVERT: state_n_s = (bitcnt_r == BW'(W - 1)) ? S_SCAN : S_CONVERT;
      S_SCAN:    state_n_s = (cand_r == hi_r) ? (last_r ? S_DONE : S_ACCEPT) : S_SCAN;
      default:   state_n_s = S_IDLE;
    endcase
  end

  // Datapath, state and registered status/result outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= S_IDLE;
      mode_r      <= 1'b0;
      last_r      <= 1'b0;
      hi_r        <= '0;
      cand_r      <= '0;
      shift_r     <= '0;
      acc_r       <= '0;
      cnt_r       <= '0;
      digits_r    <= '0;
      ndig_r      <= NW'(1);
      bitcnt_r    <= '0;
      in_ready    <= 1'b0;
      busy        <= 1'b0;
      finished    <= 1'b0;
      result      <= '0;
      match_count <= '0;
    end else begin
      state_r  <= state_n_s;
      in_ready <= (state_n_s == S_ACCEPT);
      busy     <= (state_n_s != S_IDLE) && (state_n_s != S_DONE);
      finished <= (state_n_s == S_DONE);
      case (state_r)
        S_IDLE, S_DONE: begin
          if (start) begin
            acc_r       <= '0;
            cnt_r       <= '0;
            mode_r      <= mode;
            result      <= '0;
            match_count <= '0;
          end
        end
        S_ACCEPT: begin
          if (in_valid) begin
            hi_r     <= in_hi;
            last_r   <= in_last;
            cand_r   <= in_lo;
            shift_r  <= in_lo;
            digits_r <= '0;
            bitcnt_r <= '0;
            if ((in_lo > in_hi) && in_last) begin
              result      <= acc_r;
              match_count <= cnt_r;
            end
          end
        end
        S_CONVERT: begin
          shift_r  <= shift_r << 1;
          digits_r <= dd_next_s;
          bitcnt_r <= bitcnt_r + BW'(1);
          if (bitcnt_r == BW'(W - 1)) begin
            ndig_r <= digit_count(dd_next_s);
          end
        end
        S_SCAN: begin
          acc_r <= acc_next_s;
          cnt_r <= cnt_next_s;
          // Stop on equality so hi = all-ones never reaches the incrementer.
          if (cand_r == hi_r) begin
            if (last_r) begin
              result      <= acc_next_s;
              match_count <= cnt_next_s;
            end
          end else begin
            cand_r   <= cand_r + {{(W-1){1'b0}}, 1'b1};
            digits_r <= bcd_inc_s;
            ndig_r   <= digit_count(bcd_inc_s);
          end
        end
        default: state_r <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_day_2_repeat_scan.sv
// Directed bench for day_2_repeat_scan: W=64 instance for the main ranges,
// W=8 instance for wrap-around and the all-ones upper bound.
module tb_day_2_repeat_scan;

  logic        clk;
  logic        rst;
  logic        start, mode, in_valid, in_last;
  logic [63:0] in_lo, in_hi;
  logic        in_ready, busy, finished;
  logic [63:0] result, match_count;

  logic        start8, mode8, in_valid8, in_last8;
  logic [7:0]  in_lo8, in_hi8;
  logic        in_ready8, busy8, finished8;
  logic [7:0]  result8, match_count8;

  int n_checks = 0;
  int n_fail   = 0;

  day_2_repeat_scan #(.W(64), .MAX_DIGITS(20)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_lo(in_lo), .in_hi(in_hi),
    .in_last(in_last), .busy(busy), .finished(finished),
    .result(result), .match_count(match_count)
  );

  day_2_repeat_scan #(.W(8), .MAX_DIGITS(3)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .mode(mode8),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_lo(in_lo8), .in_hi(in_hi8),
    .in_last(in_last8), .busy(busy8), .finished(finished8),
    .result(result8), .match_count(match_count8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input logic m);
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Present a range and hold it until the handshake completes; jitter randomises in_valid.
  task automatic send(input logic [63:0] lo, input logic [63:0] hi, input logic last,
                      input bit jitter);
    int k;
    k        = 0;
    in_lo    = lo;
    in_hi    = hi;
    in_last  = last;
    in_valid = jitter ? 1'($urandom_range(0, 1)) : 1'b1;
    while (!(in_ready && in_valid) && k < 2000) begin
      @(negedge clk);
      k++;
      if (jitter) in_valid = 1'($urandom_range(0, 1));
    end
    check("accept_in_time", 64'(k < 2000), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    int k;
    k = 0;
    while (!finished && k < 5000) begin
      @(negedge clk);
      k++;
    end
    check("done_in_time", 64'(k < 5000), 64'd1);
    cycles = k;
  endtask

  task automatic send_main(input bit jitter);
    send(64'd11, 64'd22, 1'b0, jitter);
    send(64'd95, 64'd115, 1'b0, jitter);
    send(64'd998, 64'd1012, 1'b0, jitter);
    send(64'd1188511880, 64'd1188511890, 1'b1, jitter);
  endtask

  initial begin
    int cyc;
    rst = 1'b0; start = 1'b0; mode = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_lo = 64'd0; in_hi = 64'd0;
    start8 = 1'b0; mode8 = 1'b0; in_valid8 = 1'b0; in_last8 = 1'b0;
    in_lo8 = 8'd0; in_hi8 = 8'd0;
    repeat (3) @(negedge clk);
    check("reset_result", result, 64'd0);
    check("reset_count", match_count, 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_finished", 64'(finished), 64'd0);
    check("reset_ready", 64'(in_ready), 64'd0);
    rst = 1'b1;

    // Mode 0 over the main ranges
    pulse_start(1'b0);
    check("start_busy", 64'(busy), 64'd1);
    check("start_ready", 64'(in_ready), 64'd1);
    send_main(1'b0);
    wait_done(cyc);
    check("m0_result", result, 64'd1188513027);
    check("m0_count", match_count, 64'd5);
    check("m0_idle", 64'(busy), 64'd0);

    // Mode 1 over the same ranges, restarted from DONE
    pulse_start(1'b1);
    check("restart_finished_drop", 64'(finished), 64'd0);
    send_main(1'b0);
    wait_done(cyc);
    check("m1_result", result, 64'd1188514137);
    check("m1_count", match_count, 64'd7);

    // Single-digit and inverted ranges contribute nothing
    pulse_start(1'b1);
    send(64'd5, 64'd5, 1'b0, 1'b0);
    send(64'd30, 64'd20, 1'b0, 1'b0);
    send(64'd0, 64'd9, 1'b1, 1'b0);
    wait_done(cyc);
    check("degen_result", result, 64'd0);
    check("degen_count", match_count, 64'd0);
    check("degen_finished", 64'(finished), 64'd1);

    // Stalled handshake plus an ignored start during SCAN of 95-115
    pulse_start(1'b0);
    send(64'd11, 64'd22, 1'b0, 1'b1);
    send(64'd95, 64'd115, 1'b0, 1'b1);
    repeat (70) @(negedge clk);
    check("midscan_busy", 64'(busy), 64'd1);
    pulse_start(1'b1);
    check("ignored_start_busy", 64'(busy), 64'd1);
    check("ignored_start_finished", 64'(finished), 64'd0);
    send(64'd998, 64'd1012, 1'b0, 1'b1);
    send(64'd1188511880, 64'd1188511890, 1'b1, 1'b1);
    wait_done(cyc);
    check("stress_result", result, 64'd1188513027);
    check("stress_count", match_count, 64'd5);

    // Reset during SCAN, then a clean rerun with exact latency
    pulse_start(1'b0);
    send(64'd95, 64'd115, 1'b1, 1'b0);
    repeat (70) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_finished", 64'(finished), 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_count", match_count, 64'd0);
    check("rst_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    pulse_start(1'b0);
    send(64'd95, 64'd115, 1'b1, 1'b0);
    wait_done(cyc);
    check("rerun_latency", 64'(cyc), 64'd85);
    check("rerun_result", result, 64'd99);
    check("rerun_count", match_count, 64'd1);

    // Narrow instance: 0..255, mode 1, sum wraps and hi is all ones
    @(negedge clk);
    start8 = 1'b1;
    mode8  = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    in_lo8 = 8'd0; in_hi8 = 8'd255; in_last8 = 1'b1; in_valid8 = 1'b1;
    cyc = 0;
    while (!in_ready8 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("w8_accept_in_time", 64'(cyc < 100), 64'd1);
    @(negedge clk);
    in_valid8 = 1'b0;
    cyc = 0;
    while (!finished8 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check("w8_done_in_time", 64'(cyc < 2000), 64'd1);
    check("w8_result", 64'(result8), 64'd60);
    check("w8_count", 64'(match_count8), 64'd11);
    check("w8_idle", 64'(busy8), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
